// File: rtl/digit_entry_counter_pkg.sv
// Shared limits and per-cycle digit event encoding for the multi-digit code-entry counter.
package digit_entry_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_BASE   = 16;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INC  = 2'd1,
        EV_DEC  = 2'd2,
        EV_CLR  = 2'd3
    } ev_t;

endpackage

// File: rtl/digit_entry_counter_btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level followed by a rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pulse_out = r_sync2 & ~r_prev;

endmodule

// File: rtl/digit_entry_counter.sv
// NUM_DIGITS modulo-BASE code-entry digits with a cursor, driven by synchronised button edges.
// Optional decrement button and logic are built only when DIGIT_DEC_EN is defined.
module digit_entry_counter
    import digit_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BASE       = 10,
    localparam int DW = $clog2(BASE),
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_inc,
    input  logic                     btn_next,
    input  logic                     btn_clr,
`ifdef DIGIT_DEC_EN
    input  logic                     btn_dec,
`endif
    output logic [NUM_DIGITS*DW-1:0] digits,
    output logic [SW-1:0]            sel,
    output logic                     wrap_pulse,
    output logic                     entry_done
);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(BASE - 1);
    localparam logic [SW-1:0] LAST_SEL   = SW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
        $error("digit_entry_counter: NUM_DIGITS out of range 1..8");
    end
    if (BASE < 2 || BASE > MAX_BASE) begin : g_bad_base
        $error("digit_entry_counter: BASE out of range 2..16");
    end

    logic          w_inc;
    logic          w_next;
    logic          w_clr;
    ev_t           w_ev;
    logic [DW-1:0] r_digits [NUM_DIGITS];
    logic [SW-1:0] r_sel;
    logic          r_wrap;
    logic          r_done;

    btn_edge_sync u_sync_inc  (.clk(clk), .rst(rst), .btn_in(btn_inc),  .pulse_out(w_inc));
    btn_edge_sync u_sync_next (.clk(clk), .rst(rst), .btn_in(btn_next), .pulse_out(w_next));
    btn_edge_sync u_sync_clr  (.clk(clk), .rst(rst), .btn_in(btn_clr),  .pulse_out(w_clr));

`ifdef DIGIT_DEC_EN
    logic w_dec;

    btn_edge_sync u_sync_dec  (.clk(clk), .rst(rst), .btn_in(btn_dec),  .pulse_out(w_dec));

    // Simultaneous inc and dec cancel; clear dominates everything.
    always_comb begin
        w_ev = EV_NONE;
        if (w_clr)              w_ev = EV_CLR;
        else if (w_inc && !w_dec) w_ev = EV_INC;
        else if (w_dec && !w_inc) w_ev = EV_DEC;
    end
`else
    always_comb begin
        w_ev = EV_NONE;
        if (w_clr)      w_ev = EV_CLR;
        else if (w_inc) w_ev = EV_INC;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '{default: '0};
            r_sel    <= '0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_done <= 1'b0;
            case (w_ev)
                EV_CLR: begin
                    r_digits <= '{default: '0};
                    r_sel    <= '0;
                end
                EV_INC: begin
                    if (r_digits[r_sel] == LAST_DIGIT) begin
                        r_digits[r_sel] <= '0;
                        r_wrap          <= 1'b1;
                    end else begin
                        r_digits[r_sel] <= r_digits[r_sel] + DW'(1);
                    end
                end
`ifdef DIGIT_DEC_EN
                EV_DEC: begin
                    if (r_digits[r_sel] == '0) begin
                        r_digits[r_sel] <= LAST_DIGIT;
                        r_wrap          <= 1'b1;
                    end else begin
                        r_digits[r_sel] <= r_digits[r_sel] - DW'(1);
                    end
                end
`endif
                default: ;
            endcase
            // Cursor moves on the same edge; the digit update above used the old cursor.
            if (w_next && w_ev != EV_CLR) begin
                if (r_sel == LAST_SEL) begin
                    r_sel  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_sel <= r_sel + SW'(1);
                end
            end
        end
    end

    always_comb begin
        digits = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digits[i*DW +: DW] = r_digits[i];
        end
    end

    assign sel        = r_sel;
    assign wrap_pulse = r_wrap;
    assign entry_done = r_done;

endmodule

// File: tb/tb_digit_entry_counter.sv
// Directed bench for digit_entry_counter: defaults (4 x mod-10), or 2 x mod-16 with DIGIT_DEC_EN.
module tb_digit_entry_counter;

`ifdef DIGIT_DEC_EN
    localparam int ND = 2;
    localparam int BS = 16;
`else
    localparam int ND = 4;
    localparam int BS = 10;
`endif
    localparam int DWB = 4;
    localparam int SWB = (ND > 1) ? $clog2(ND) : 1;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              btn_inc  = 1'b0;
    logic              btn_next = 1'b0;
    logic              btn_clr  = 1'b0;
`ifdef DIGIT_DEC_EN
    logic              btn_dec  = 1'b0;
`endif
    logic [ND*DWB-1:0] digits;
    logic [SWB-1:0]    sel;
    logic              wrap_pulse;
    logic              entry_done;

    int tests = 0;
    int fails = 0;
    int wraps = 0;

    always #5 clk = ~clk;

    digit_entry_counter #(
        .NUM_DIGITS(ND),
        .BASE(BS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_inc(btn_inc),
        .btn_next(btn_next),
        .btn_clr(btn_clr),
`ifdef DIGIT_DEC_EN
        .btn_dec(btn_dec),
`endif
        .digits(digits),
        .sel(sel),
        .wrap_pulse(wrap_pulse),
        .entry_done(entry_done)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise buttons for one cycle, then wait until just after the acting (3rd) edge.
    task automatic press(input logic inc, input logic nxt, input logic clr);
        btn_inc = inc; btn_next = nxt; btn_clr = clr;
        tick(1);
        btn_inc = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
        tick(2);
    endtask

`ifdef DIGIT_DEC_EN
    task automatic press4(input logic inc, input logic nxt, input logic clr, input logic dec);
        btn_inc = inc; btn_next = nxt; btn_clr = clr; btn_dec = dec;
        tick(1);
        btn_inc = 1'b0; btn_next = 1'b0; btn_clr = 1'b0; btn_dec = 1'b0;
        tick(2);
    endtask
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(2);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_wrap", 32'(wrap_pulse), 0);
        chk("rst_done", 32'(entry_done), 0);
        rst = 1'b0;
        tick(1);

`ifdef DIGIT_DEC_EN
        press4(0, 0, 0, 1);
        chk("dec_underflow_d0", 32'(digits[3:0]), 32'hF);
        chk("dec_underflow_wrap", 32'(wrap_pulse), 1);
        press4(1, 0, 0, 1);
        chk("incdec_d0", 32'(digits[3:0]), 32'hF);
        chk("incdec_wrap", 32'(wrap_pulse), 0);
        press4(1, 0, 0, 0);
        chk("inc_overflow_d0", 32'(digits[3:0]), 0);
        chk("inc_overflow_wrap", 32'(wrap_pulse), 1);
        press4(0, 1, 0, 1);
        chk("decnext_digits", 32'(digits), 32'h0F);
        chk("decnext_sel", 32'(sel), 1);
        chk("decnext_wrap", 32'(wrap_pulse), 1);
        press4(1, 0, 0, 0);
        chk("inc_d1_digits", 32'(digits), 32'h1F);
        chk("inc_d1_wrap", 32'(wrap_pulse), 0);
        press4(0, 1, 0, 0);
        chk("last_next_sel", 32'(sel), 0);
        chk("last_next_done", 32'(entry_done), 1);
        press4(0, 0, 1, 1);
        chk("clrdec_digits", 32'(digits), 0);
        chk("clrdec_wrap", 32'(wrap_pulse), 0);
`else
        begin
            int exp_d0 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
            int exp_w  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
            for (int k = 0; k < 12; k++) begin
                press(1, 0, 0);
                chk($sformatf("inc%0d_d0", k + 1), 32'(digits[3:0]), 32'(exp_d0[k]));
                chk($sformatf("inc%0d_wrap", k + 1), 32'(wrap_pulse), 32'(exp_w[k]));
                if (wrap_pulse) wraps++;
                if (k == 9) begin
                    tick(1);
                    chk("wrap_one_cycle", 32'(wrap_pulse), 0);
                end
            end
            chk("wrap_count", 32'(wraps), 1);
            chk("inc_other_digits", 32'(digits[15:4]), 0);
        end

        press(0, 0, 1);
        chk("clr1_digits", 32'(digits), 0);

        repeat (3) press(1, 0, 0);
        press(0, 1, 0);
        chk("next1_sel", 32'(sel), 1);
        chk("next1_done", 32'(entry_done), 0);
        repeat (5) press(1, 0, 0);
        press(0, 1, 0);
        chk("next2_sel", 32'(sel), 2);
        chk("next2_done", 32'(entry_done), 0);
        press(0, 1, 0);
        chk("next3_sel", 32'(sel), 3);
        chk("next3_done", 32'(entry_done), 0);
        press(0, 1, 0);
        chk("next4_sel", 32'(sel), 0);
        chk("next4_done", 32'(entry_done), 1);
        chk("entry_digits", 32'(digits), 32'h0053);
        tick(1);
        chk("done_one_cycle", 32'(entry_done), 0);

        press(0, 1, 0);
        press(1, 1, 0);
        chk("incnext_digits", 32'(digits), 32'h0063);
        chk("incnext_sel", 32'(sel), 2);

        press(0, 0, 1);
        repeat (9) press(1, 0, 0);
        press(0, 1, 0);
        repeat (4) press(1, 0, 0);
        press(0, 1, 0);
        repeat (7) press(1, 0, 0);
        press(0, 1, 0);
        repeat (2) press(1, 0, 0);
        chk("setup_digits", 32'(digits), 32'h2749);
        chk("setup_sel", 32'(sel), 3);
        press(1, 0, 1);
        chk("clrinc_digits", 32'(digits), 0);
        chk("clrinc_sel", 32'(sel), 0);
        chk("clrinc_wrap", 32'(wrap_pulse), 0);
        chk("clrinc_done", 32'(entry_done), 0);

        btn_inc = 1'b1;
        tick(50);
        chk("hold50_digits", 32'(digits), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_digits", 32'(digits), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("rel_edge2_digits", 32'(digits), 0);
        tick(1);
        chk("rel_edge3_digits", 32'(digits), 1);
        tick(10);
        chk("rel_hold_digits", 32'(digits), 1);
        btn_inc = 1'b0;
        tick(3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
